// File: rtl/control_pipe.sv
// Pipelined main control: D-stage decode carried through E/M/W with stall/flush and a multi-cycle mult hold in E.
// Optional I-type ALU decode (addi/andi/ori/slti) is enabled by defining CTRL_IMM_EN.
module control_pipe #(
   parameter int ALUCTRL_W   = 4,
   parameter int MULT_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [5:0]           Op,
   input  logic [5:0]           Funct,
   input  logic                 StallD,
   input  logic                 FlushE,
   output logic                 RegWriteD,
   output logic                 MemtoRegD,
   output logic                 MemWriteD,
   output logic                 ALUSrcD,
   output logic                 RegDstD,
   output logic                 BranchD,
   output logic                 BranchNeD,
   output logic                 JToPCD,
   output logic                 LinkD,
   output logic [ALUCTRL_W-1:0] ALUControlD,
   output logic                 RegWriteE,
   output logic                 MemtoRegE,
   output logic                 MemWriteE,
   output logic                 ALUSrcE,
   output logic                 RegDstE,
   output logic                 LinkE,
   output logic [ALUCTRL_W-1:0] ALUControlE,
   output logic                 RegWriteM,
   output logic                 MemtoRegM,
   output logic                 MemWriteM,
   output logic                 LinkM,
   output logic                 RegWriteW,
   output logic                 MemtoRegW,
   output logic                 LinkW,
   output logic                 MultBusy
);

   typedef struct packed {
      logic                 RegWrite;
      logic                 MemtoReg;
      logic                 MemWrite;
      logic                 ALUSrc;
      logic                 RegDst;
      logic                 Link;
      logic [ALUCTRL_W-1:0] ALUControl;
   } ectrl_t;

   typedef struct packed {
      logic RegWrite;
      logic MemtoReg;
      logic MemWrite;
      logic Link;
   } mctrl_t;

   typedef struct packed {
      logic RegWrite;
      logic MemtoReg;
      logic Link;
   } wctrl_t;

   localparam logic [ALUCTRL_W-1:0] ALU_MULT = ALUCTRL_W'(4'b1000);

   ectrl_t     w_dec;
   logic       w_branch, w_branch_ne, w_jtopc;
   logic       w_busy;
   ectrl_t     r_e;
   mctrl_t     r_m;
   wctrl_t     r_w;
   logic [4:0] r_cnt;

   always_comb begin
      w_dec       = '0;
      w_branch    = 1'b0;
      w_branch_ne = 1'b0;
      w_jtopc     = 1'b0;
      case (Op)
         6'b000000: begin
            w_dec.RegWrite = 1'b1;
            w_dec.RegDst   = 1'b1;
            case (Funct)
               6'b100000: w_dec.ALUControl = ALUCTRL_W'(4'b0010);
               6'b100010: w_dec.ALUControl = ALUCTRL_W'(4'b0110);
               6'b100100: w_dec.ALUControl = ALUCTRL_W'(4'b0000);
               6'b100101: w_dec.ALUControl = ALUCTRL_W'(4'b0001);
               6'b101010: w_dec.ALUControl = ALUCTRL_W'(4'b0111);
               6'b011000: w_dec.ALUControl = ALU_MULT;
               6'b100110: w_dec.ALUControl = ALUCTRL_W'(4'b1101);
               6'b100111: w_dec.ALUControl = ALUCTRL_W'(4'b1100);
               default:   w_dec.ALUControl = '0;
            endcase
         end
         6'b100011: begin
            w_dec.RegWrite   = 1'b1;
            w_dec.ALUSrc     = 1'b1;
            w_dec.MemtoReg   = 1'b1;
            w_dec.ALUControl = ALUCTRL_W'(4'b0010);
         end
         6'b101011: begin
            w_dec.ALUSrc     = 1'b1;
            w_dec.MemWrite   = 1'b1;
            w_dec.ALUControl = ALUCTRL_W'(4'b0010);
         end
         6'b000100: begin
            w_branch         = 1'b1;
            w_dec.ALUControl = ALUCTRL_W'(4'b0110);
         end
         6'b000101: begin
            w_branch         = 1'b1;
            w_branch_ne      = 1'b1;
            w_dec.ALUControl = ALUCTRL_W'(4'b0110);
         end
         6'b000010: w_jtopc = 1'b1;
         6'b000011: begin
            // jal writes r31 with PC+8; Link steers the writeback mux downstream
            w_jtopc        = 1'b1;
            w_dec.RegWrite = 1'b1;
            w_dec.Link     = 1'b1;
         end
`ifdef CTRL_IMM_EN
         6'b001000: begin
            w_dec.RegWrite   = 1'b1;
            w_dec.ALUSrc     = 1'b1;
            w_dec.ALUControl = ALUCTRL_W'(4'b0010);
         end
         6'b001100: begin
            w_dec.RegWrite   = 1'b1;
            w_dec.ALUSrc     = 1'b1;
            w_dec.ALUControl = ALUCTRL_W'(4'b0000);
         end
         6'b001101: begin
            w_dec.RegWrite   = 1'b1;
            w_dec.ALUSrc     = 1'b1;
            w_dec.ALUControl = ALUCTRL_W'(4'b0001);
         end
         6'b001010: begin
            w_dec.RegWrite   = 1'b1;
            w_dec.ALUSrc     = 1'b1;
            w_dec.ALUControl = ALUCTRL_W'(4'b0111);
         end
`endif
         default: ;
      endcase
   end

   assign w_busy = (r_cnt != 5'd0);

   // While a mult is busy E holds, M takes bubbles, and stall/flush are ignored.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_e   <= '0;
         r_m   <= '0;
         r_w   <= '0;
         r_cnt <= '0;
      end else begin
         r_w <= '{RegWrite: r_m.RegWrite, MemtoReg: r_m.MemtoReg, Link: r_m.Link};
         if (w_busy) begin
            r_m   <= '0;
            r_cnt <= r_cnt - 5'd1;
         end else begin
            r_m <= '{RegWrite: r_e.RegWrite, MemtoReg: r_e.MemtoReg,
                     MemWrite: r_e.MemWrite, Link: r_e.Link};
            if (FlushE || StallD) begin
               r_e <= '0;
            end else begin
               r_e <= w_dec;
               if (w_dec.ALUControl == ALU_MULT) r_cnt <= 5'(MULT_CYCLES - 1);
            end
         end
      end
   end

   assign RegWriteD   = w_dec.RegWrite;
   assign MemtoRegD   = w_dec.MemtoReg;
   assign MemWriteD   = w_dec.MemWrite;
   assign ALUSrcD     = w_dec.ALUSrc;
   assign RegDstD     = w_dec.RegDst;
   assign BranchD     = w_branch;
   assign BranchNeD   = w_branch_ne;
   assign JToPCD      = w_jtopc;
   assign LinkD       = w_dec.Link;
   assign ALUControlD = w_dec.ALUControl;

   assign RegWriteE   = r_e.RegWrite;
   assign MemtoRegE   = r_e.MemtoReg;
   assign MemWriteE   = r_e.MemWrite;
   assign ALUSrcE     = r_e.ALUSrc;
   assign RegDstE     = r_e.RegDst;
   assign LinkE       = r_e.Link;
   assign ALUControlE = r_e.ALUControl;

   assign RegWriteM   = r_m.RegWrite;
   assign MemtoRegM   = r_m.MemtoReg;
   assign MemWriteM   = r_m.MemWrite;
   assign LinkM       = r_m.Link;

   assign RegWriteW   = r_w.RegWrite;
   assign MemtoRegW   = r_w.MemtoReg;
   assign LinkW       = r_w.Link;

   assign MultBusy    = w_busy;

endmodule

// File: tb/tb_control_pipe.sv
// Bench for control_pipe: directed steps then random traffic against a cycle-level reference model.
module tb_control_pipe;
   localparam int ALUW = 4;
   localparam int MC   = 4;

   logic clk = 1'b0;
   logic reset, StallD, FlushE;
   logic [5:0] Op, Funct;
   logic RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, BranchD, BranchNeD, JToPCD, LinkD;
   logic [ALUW-1:0] ALUControlD, ALUControlE;
   logic RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, LinkE;
   logic RegWriteM, MemtoRegM, MemWriteM, LinkM;
   logic RegWriteW, MemtoRegW, LinkW, MultBusy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   control_pipe #(.ALUCTRL_W(ALUW), .MULT_CYCLES(MC)) dut (
      .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .StallD(StallD), .FlushE(FlushE),
      .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD), .ALUSrcD(ALUSrcD),
      .RegDstD(RegDstD), .BranchD(BranchD), .BranchNeD(BranchNeD), .JToPCD(JToPCD), .LinkD(LinkD),
      .ALUControlD(ALUControlD),
      .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE),
      .RegDstE(RegDstE), .LinkE(LinkE), .ALUControlE(ALUControlE),
      .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM), .LinkM(LinkM),
      .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .LinkW(LinkW), .MultBusy(MultBusy)
   );

   typedef struct {
      bit rw, mtr, mw, as, rd, br, bne, j, lk;
      bit [3:0] alu;
   } dec_t;

   // Model state: control word per stage, plus how long the current mult has sat in E.
   dec_t e_q, m_q, w_q;
   bit   mult_live;
   int   mult_occ;

   function automatic dec_t zero_dec();
      dec_t d;
      d = '{default: 0};
      return d;
   endfunction

   function automatic dec_t decode(input bit [5:0] op, input bit [5:0] fn);
      dec_t d;
      d = zero_dec();
      if (op == 6'b000000) begin
         d.rw = 1; d.rd = 1;
         if      (fn == 6'b100000) d.alu = 4'b0010;
         else if (fn == 6'b100010) d.alu = 4'b0110;
         else if (fn == 6'b100101) d.alu = 4'b0001;
         else if (fn == 6'b101010) d.alu = 4'b0111;
         else if (fn == 6'b011000) d.alu = 4'b1000;
         else if (fn == 6'b100110) d.alu = 4'b1101;
         else if (fn == 6'b100111) d.alu = 4'b1100;
      end else if (op == 6'b100011) begin d.rw = 1; d.as = 1; d.mtr = 1; d.alu = 4'b0010; end
      else if (op == 6'b101011) begin d.as = 1; d.mw = 1; d.alu = 4'b0010; end
      else if (op == 6'b000100) begin d.br = 1; d.alu = 4'b0110; end
      else if (op == 6'b000101) begin d.br = 1; d.bne = 1; d.alu = 4'b0110; end
      else if (op == 6'b000010) d.j = 1;
      else if (op == 6'b000011) begin d.j = 1; d.rw = 1; d.lk = 1; end
`ifdef CTRL_IMM_EN
      else if (op == 6'b001000) begin d.rw = 1; d.as = 1; d.alu = 4'b0010; end
      else if (op == 6'b001100) begin d.rw = 1; d.as = 1; d.alu = 4'b0000; end
      else if (op == 6'b001101) begin d.rw = 1; d.as = 1; d.alu = 4'b0001; end
      else if (op == 6'b001010) begin d.rw = 1; d.as = 1; d.alu = 4'b0111; end
`endif
      return d;
   endfunction

   function automatic bit model_busy();
      return mult_live && (mult_occ < MC);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_d(input dec_t d);
      chk("RegWriteD", 32'(RegWriteD), 32'(d.rw));
      chk("MemtoRegD", 32'(MemtoRegD), 32'(d.mtr));
      chk("MemWriteD", 32'(MemWriteD), 32'(d.mw));
      chk("ALUSrcD", 32'(ALUSrcD), 32'(d.as));
      chk("RegDstD", 32'(RegDstD), 32'(d.rd));
      chk("BranchD", 32'(BranchD), 32'(d.br));
      chk("BranchNeD", 32'(BranchNeD), 32'(d.bne));
      chk("JToPCD", 32'(JToPCD), 32'(d.j));
      chk("LinkD", 32'(LinkD), 32'(d.lk));
      chk("ALUControlD", 32'(ALUControlD), 32'(d.alu));
   endtask

   task automatic check_regs();
      chk("RegWriteE", 32'(RegWriteE), 32'(e_q.rw));
      chk("MemtoRegE", 32'(MemtoRegE), 32'(e_q.mtr));
      chk("MemWriteE", 32'(MemWriteE), 32'(e_q.mw));
      chk("ALUSrcE", 32'(ALUSrcE), 32'(e_q.as));
      chk("RegDstE", 32'(RegDstE), 32'(e_q.rd));
      chk("LinkE", 32'(LinkE), 32'(e_q.lk));
      chk("ALUControlE", 32'(ALUControlE), 32'(e_q.alu));
      chk("RegWriteM", 32'(RegWriteM), 32'(m_q.rw));
      chk("MemtoRegM", 32'(MemtoRegM), 32'(m_q.mtr));
      chk("MemWriteM", 32'(MemWriteM), 32'(m_q.mw));
      chk("LinkM", 32'(LinkM), 32'(m_q.lk));
      chk("RegWriteW", 32'(RegWriteW), 32'(w_q.rw));
      chk("MemtoRegW", 32'(MemtoRegW), 32'(w_q.mtr));
      chk("LinkW", 32'(LinkW), 32'(w_q.lk));
      chk("MultBusy", 32'(MultBusy), 32'(model_busy()));
   endtask

   // One clock: drive inputs at the falling edge, check decode, advance model across the rising edge, check registers.
   task automatic cycle(input bit [5:0] op, input bit [5:0] fn, input bit stall, input bit flush, input bit rst);
      dec_t d;
      bit   busy;
      Op = op; Funct = fn; StallD = stall; FlushE = flush; reset = rst;
      #1;
      d = decode(op, fn);
      check_d(d);
      busy = model_busy();
      @(negedge clk);
      if (rst) begin
         e_q = zero_dec(); m_q = zero_dec(); w_q = zero_dec();
         mult_live = 0; mult_occ = 0;
      end else begin
         w_q = m_q;
         m_q = busy ? zero_dec() : e_q;
         if (busy) mult_occ++;
         else if (stall || flush) begin
            e_q = zero_dec(); mult_live = 0;
         end else begin
            e_q = d; e_q.br = 0; e_q.bne = 0; e_q.j = 0;
            mult_live = (d.alu == 4'b1000);
            mult_occ  = 1;
         end
      end
      check_regs();
   endtask

   localparam bit [5:0] R = 6'b000000;
   localparam bit [5:0] F_MULT = 6'b011000;
   localparam bit [5:0] F_ADD  = 6'b100000;

   initial begin
      bit [5:0] ops [12];
      bit [5:0] fns [10];
      ops = '{6'b000000, 6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
              6'b000010, 6'b000011, 6'b001000, 6'b001100, 6'b001101, 6'b001010};
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b011000,
              6'b100110, 6'b100111, 6'b000000, 6'b111111};
      e_q = zero_dec(); m_q = zero_dec(); w_q = zero_dec();
      mult_live = 0; mult_occ = 0;
      Op = '0; Funct = '0; StallD = 0; FlushE = 0; reset = 1;

      // reset with lw presented
      cycle(6'b100011, 6'b0, 0, 0, 1);
      cycle(6'b100011, 6'b0, 0, 0, 1);
      // sub flowing through E/M/W
      cycle(R, 6'b100010, 0, 0, 0);
      cycle(6'b111111, 6'b0, 0, 0, 0);
      cycle(6'b111111, 6'b0, 0, 0, 0);
      cycle(6'b111111, 6'b0, 0, 0, 0);
      // sw under stall, then released
      cycle(6'b101011, 6'b0, 1, 0, 0);
      cycle(6'b101011, 6'b0, 0, 0, 0);
      // jal to W
      cycle(6'b000011, 6'b0, 0, 0, 0);
      cycle(6'b111111, 6'b0, 0, 0, 0);
      cycle(6'b111111, 6'b0, 0, 0, 0);
      cycle(6'b111111, 6'b0, 0, 0, 0);
      // addi decode, depends on build
      cycle(6'b001000, 6'b0, 0, 0, 0);
      // mult with flush during the hold
      cycle(R, F_MULT, 0, 0, 0);
      cycle(R, F_ADD, 0, 1, 0);
      cycle(R, F_ADD, 1, 1, 0);
      cycle(R, F_ADD, 0, 0, 0);
      cycle(R, F_ADD, 0, 0, 0);
      cycle(6'b111111, 6'b0, 0, 0, 0);
      // back-to-back mults
      for (int i = 0; i < 10; i++) cycle(R, F_MULT, 0, 0, 0);
      // reset mid-mult
      cycle(R, F_MULT, 0, 0, 0);
      cycle(R, F_ADD, 0, 0, 0);
      cycle(R, F_ADD, 0, 0, 1);
      cycle(R, F_ADD, 0, 0, 0);
      cycle(R, F_ADD, 0, 0, 0);

      for (int i = 0; i < 400; i++) begin
         bit [5:0] op, fn;
         op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 11)];
         fn = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fns[$urandom_range(0, 9)];
         cycle(op, fn, ($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0),
               ($urandom_range(0, 40) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/control_pipe.md
# control_pipe

Pipelined main control unit for the 5-stage MIPS core. Decodes Op/Funct in Decode, then carries the control word through E, M and W pipeline registers with hazard stall and flush. Sequences a multi-cycle multiply by holding E and requesting an upstream stall. Replaces the purely combinational decoder, adding bne/jal, optional I-type ALU ops and a parametrised ALU-control width.

## Interface
Parameters:
- ALUCTRL_W, 4, width of ALUControl buses; legal ≥4; codes zero-extended.
- MULT_CYCLES, 4, total cycles a mult occupies E; legal 1..16.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- Op  in  6  opcode of instruction in D.
- Funct  in  6  funct field of instruction in D.
- StallD  in  1  hazard unit holds F/D; E receives a bubble.
- FlushE  in  1  E receives a bubble.
- RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, BranchD, BranchNeD, JToPCD, LinkD  out  1 each  combinational D-stage decode.
- ALUControlD  out  ALUCTRL_W  combinational D-stage ALU op.
- RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, LinkE  out  1 each  E register.
- ALUControlE  out  ALUCTRL_W  E register.
- RegWriteM, MemtoRegM, MemWriteM, LinkM  out  1 each  M register.
- RegWriteW, MemtoRegW, LinkW  out  1 each  W register.
- MultBusy  out  1  mult in progress; hazard unit must stall F and D.

## Operation
- Decode (all unlisted outputs 0):
  - Op 000000 R-type: RegDst=RegWrite=1; Funct 100000 add→0010, 100010 sub→0110, 100100 and→0000, 100101 or→0001, 101010 slt→0111, 011000 mult→1000, 100110 xor→1101, 100111 nor→1100, other→0000.
  - 100011 lw: RegWrite, ALUSrc, MemtoReg, ALU 0010.
  - 101011 sw: ALUSrc, MemWrite, ALU 0010.
  - 000100 beq: Branch, ALU 0110.
  - 000101 bne: Branch, BranchNe, ALU 0110.
  - 000010 j: JToPC.
  - 000011 jal: JToPC, RegWrite, Link (writes r31 with PC+8 downstream).
  - Any other opcode: all zero (treated as nop).
- E update priority: reset → zero; MultBusy → hold; FlushE or StallD → zero (bubble); else load D decode.
- M update: reset or MultBusy → zero; else copy E. W: reset → zero; else copy M.
- Mult counter cnt (5 bits): on the edge E loads a word with ALUControl=1000, cnt ← MULT_CYCLES-1. While cnt≠0: cnt decrements each cycle. MultBusy = (cnt≠0), registered-derived, no combinational path from inputs.
- FlushE and StallD ignored while MultBusy.

## Timing
- D outputs: zero latency, combinational from Op/Funct.
- D→E→M→W: one cycle per stage in absence of stall.
- Mult: resides in E for exactly MULT_CYCLES cycles; MultBusy high MULT_CYCLES-1 cycles starting the cycle after E loads it; MULT_CYCLES=1 → MultBusy never asserts.
- Back-to-back mult: second mult held in D by MultBusy, loads E the cycle MultBusy drops, restarts count.
- Reset mid-mult: cnt and all stage registers zero on the next edge; MultBusy low the following cycle.
- Reset values: every E/M/W output 0, ALUControlE 0, MultBusy 0.

## Configuration
- CTRL_IMM_EN defined: adds I-type decode, all with RegWrite=1, ALUSrc=1, RegDst=0: 001000 addi→0010, 001100 andi→0000, 001101 ori→0001, 001010 slti→0111.
- Undefined: those opcodes fall to default (all zero); no other behaviour changes.

## Test plan
- Reset held 2 cycles with Op=100011 → all E/M/W outputs and MultBusy 0; D outputs show lw decode.
- Op=000000, Funct=100010 → ALUControlE=0110, RegWriteE=1 next cycle; RegWriteM=1 at +2, RegWriteW=1 at +3.
- Mult with MULT_CYCLES=4 → MultBusy high cycles 2-4 after load, ALUControlE=1000 held 4 cycles, M receives zeros during hold, FlushE=1 mid-hold has no effect.
- Op=101011 with StallD=1 → MemWriteE=0 (bubble); StallD=0 next cycle → MemWriteE=1.
- Op=000011 → JToPCD=1, LinkD=1; LinkW=1 and RegWriteW=1 three cycles later.
- Op=001000: with CTRL_IMM_EN → RegWriteD=1, ALUSrcD=1, ALUControlD=0010; without → all D outputs 0.
